// File: rtl/fwvip_wb_target_core.sv
// fwvip_wb_target_core
//   Wishbone classic target front-end. Each WB cycle (tcyc&&tstb) becomes one
//   packed ready/valid request {adr,dat_w,we,sel}. The matching response
//   {dat_r,err} goes back to the bus as a one-cycle tack or terr with read data.
//   If the back-end does not answer within TIMEOUT cycles, the bus gets terr and
//   the late response is drained silently later. All outputs are registered.
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   tadr/tdat_w/twe/tsel   WB request inputs; tstb/tcyc WB strobe/cycle
//   tdat_r/tack/terr       WB response outputs
//   req_dat/req_valid/req_ready   RV request channel (out)
//   rsp_dat/rsp_valid/rsp_ready   RV response channel (in), rsp_dat[0] = err
module fwvip_wb_target_core #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 16,
  localparam int SEL_W      = DATA_WIDTH / 8,
  localparam int REQ_W      = ADDR_WIDTH + DATA_WIDTH + 1 + SEL_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] tadr,
  input  logic [DATA_WIDTH-1:0] tdat_w,
  output logic [DATA_WIDTH-1:0] tdat_r,
  input  logic                  twe,
  input  logic                  tstb,
  input  logic [SEL_W-1:0]      tsel,
  output logic                  tack,
  output logic                  terr,
  input  logic                  tcyc,
  output logic [REQ_W-1:0]      req_dat,
  output logic                  req_valid,
  input  logic                  req_ready,
  input  logic [DATA_WIDTH:0]   rsp_dat,
  input  logic                  rsp_valid,
  output logic                  rsp_ready
);

  // TIMEOUT==0 disables the timeout; keep a 1-bit counter so widths stay legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RSP, S_ACK, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tack_q, tack_d, terr_q, terr_d;
  logic                  req_valid_q, req_valid_d, rsp_ready_q, rsp_ready_d;
  logic [DATA_WIDTH-1:0] tdat_r_q, tdat_r_d;
  logic [REQ_W-1:0]      req_dat_q, req_dat_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tack_q      <= 1'b0;
      terr_q      <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      tdat_r_q    <= '0;
      req_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tack_q      <= tack_d;
      terr_q      <= terr_d;
      req_valid_q <= req_valid_d;
      rsp_ready_q <= rsp_ready_d;
      tdat_r_q    <= tdat_r_d;
      req_dat_q   <= req_dat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tack_d      = tack_q;
    terr_d      = terr_q;
    req_valid_d = req_valid_q;
    rsp_ready_d = rsp_ready_q;
    tdat_r_d    = tdat_r_q;
    req_dat_d   = req_dat_q;
    unique case (state_q)
      S_IDLE: begin
        if (tcyc && tstb) begin
          req_dat_d   = {tadr, tdat_w, twe, tsel};
          req_valid_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          rsp_ready_d = 1'b1;
          cnt_d       = '0;
          // An abandoned cycle still owes us a response; drain it.
          state_d     = tcyc ? S_RSP : S_DRAIN;
        end
      end
      S_RSP: begin
        if (rsp_valid) begin
          tdat_r_d    = rsp_dat[DATA_WIDTH:1];
          tack_d      = ~rsp_dat[0];
          terr_d      = rsp_dat[0];
          rsp_ready_d = 1'b0;
          state_d     = S_ACK;
        end else if (!tcyc) begin
          state_d = S_DRAIN;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          // rsp_ready stays high so DRAIN can swallow the late response.
          terr_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK: begin
        tack_d  = 1'b0;
        terr_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        terr_d = 1'b0;
        if (rsp_valid) begin
          rsp_ready_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tack      = tack_q;
  assign terr      = terr_q;
  assign req_valid = req_valid_q;
  assign rsp_ready = rsp_ready_q;
  assign tdat_r    = tdat_r_q;
  assign req_dat   = req_dat_q;

endmodule

// File: tb/tb_fwvip_wb_target_core.sv
module tb_fwvip_wb_target_core;
  localparam int AW = 32, DW = 32, SW = DW / 8, RW = AW + DW + 1 + SW;

  logic          clock = 1'b0, reset = 1'b1;
  logic [AW-1:0] tadr = '0;
  logic [DW-1:0] tdat_w = '0, tdat_r;
  logic          twe = 1'b0, tstb = 1'b0, tcyc = 1'b0, tack, terr;
  logic [SW-1:0] tsel = '0;
  logic [RW-1:0] req_dat;
  logic          req_valid, req_ready = 1'b0;
  logic [DW:0]   rsp_dat = '0;
  logic          rsp_valid = 1'b0, rsp_ready;

  int vectors = 0, miscompares = 0;

  fwvip_wb_target_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .tadr(tadr), .tdat_w(tdat_w), .tdat_r(tdat_r),
    .twe(twe), .tstb(tstb), .tsel(tsel), .tack(tack), .terr(terr), .tcyc(tcyc),
    .req_dat(req_dat), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_dat(rsp_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic bus_start(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic we, input logic [SW-1:0] s);
    tadr = a; tdat_w = d; twe = we; tsel = s; tcyc = 1'b1; tstb = 1'b1;
  endtask

  task automatic bus_idle();
    tcyc = 1'b0; tstb = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    vectors++; if ({tack, terr, req_valid, rsp_ready} !== 4'b0) begin miscompares++; $display("FAIL rst_ctrl: got %b want 0000", {tack, terr, req_valid, rsp_ready}); end
    vectors++; if ({tdat_r, req_dat} !== '0) begin miscompares++; $display("FAIL rst_data: got %h/%h want 0", tdat_r, req_dat); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    req_ready = 1'b1;
    bus_start(32'h1000, 32'hDEADBEEF, 1'b1, 4'hF);
    tick(); // edge 0
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL wr_req_valid: got %b want 1", req_valid); end
    vectors++; if (req_dat !== {32'h1000, 32'hDEADBEEF, 1'b1, 4'hF}) begin miscompares++; $display("FAIL wr_req_dat: got %h want %h", req_dat, {32'h1000, 32'hDEADBEEF, 1'b1, 4'hF}); end
    tick(); // edge 1: handshake
    vectors++; if ({req_valid, rsp_ready, tack} !== 3'b010) begin miscompares++; $display("FAIL wr_hs: got %b want 010", {req_valid, rsp_ready, tack}); end
    rsp_valid = 1'b1; rsp_dat = '0;
    tick(); // edge 2: response accepted
    vectors++; if ({tack, terr, rsp_ready} !== 3'b100) begin miscompares++; $display("FAIL wr_ack: got %b want 100", {tack, terr, rsp_ready}); end
    bus_idle();
    tick();
    vectors++; if ({tack, terr} !== 2'b00) begin miscompares++; $display("FAIL wr_ack_clear: got %b want 00", {tack, terr}); end
  endtask

  task automatic test_read();
    bus_start(32'h2000, 32'h0, 1'b0, 4'hF);
    tick();
    vectors++; if (req_dat[SW] !== 1'b0 || req_dat[RW-1 -: AW] !== 32'h2000) begin miscompares++; $display("FAIL rd_req: got we=%b adr=%h want we=0 adr=2000", req_dat[SW], req_dat[RW-1 -: AW]); end
    tick();
    rsp_valid = 1'b1; rsp_dat = {32'h12345678, 1'b0};
    tick();
    vectors++; if (tack !== 1'b1 || tdat_r !== 32'h12345678) begin miscompares++; $display("FAIL rd_data: got tack=%b dat=%h want 1/12345678", tack, tdat_r); end
    bus_idle();
    tick();
  endtask

  task automatic test_err_rsp();
    bus_start(32'h2004, 32'h0, 1'b0, 4'h3);
    tick(); tick();
    rsp_valid = 1'b1; rsp_dat = {32'hCAFE0000, 1'b1};
    tick();
    vectors++; if ({tack, terr} !== 2'b01) begin miscompares++; $display("FAIL err_rsp: got tack/terr=%b want 01", {tack, terr}); end
    bus_idle();
    tick();
    vectors++; if ({tack, terr} !== 2'b00) begin miscompares++; $display("FAIL err_clear: got %b want 00", {tack, terr}); end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] held;
    req_ready = 1'b0;
    bus_start(32'h4000, 32'hA5A5_0F0F, 1'b1, 4'h6);
    tick();
    held = {32'h4000, 32'hA5A5_0F0F, 1'b1, 4'h6};
    tadr = 32'hFFFF_FFFF; tdat_w = 32'h0; // bus changes must not leak into req_dat
    for (int i = 0; i < 5; i++) begin
      vectors++; if (req_valid !== 1'b1 || req_dat !== held || tack !== 1'b0 || terr !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b dat=%h ack=%b err=%b want 1/%h/0/0", i, req_valid, req_dat, tack, terr, held); end
      tick();
    end
    req_ready = 1'b1;
    tick();
    vectors++; if ({req_valid, rsp_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_hs: got %b want 01", {req_valid, rsp_ready}); end
    rsp_valid = 1'b1; rsp_dat = '0;
    tick();
    vectors++; if (tack !== 1'b1) begin miscompares++; $display("FAIL bp_ack: got %b want 1", tack); end
    bus_idle();
    tick();
  endtask

  task automatic test_timeout();
    bus_start(32'h5000, 32'h1111_2222, 1'b1, 4'hF);
    tick(); tick(); // handshake, first RSP cycle begins
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (terr !== 1'b0) begin miscompares++; $display("FAIL to_early[%0d]: got terr=%b want 0", i, terr); end
    end
    tick(); // end of 4th RSP cycle
    vectors++; if ({tack, terr} !== 2'b01) begin miscompares++; $display("FAIL to_terr: got %b want 01", {tack, terr}); end
    // New request while draining must wait.
    bus_start(32'h6000, 32'h3333_4444, 1'b1, 4'hF);
    tick();
    vectors++; if ({terr, rsp_ready, req_valid} !== 3'b010) begin miscompares++; $display("FAIL to_drain: got terr/rdy/v=%b want 010", {terr, rsp_ready, req_valid}); end
    repeat (3) tick();
    rsp_valid = 1'b1; rsp_dat = {32'h9999_9999, 1'b0};
    tick();
    vectors++; if ({tack, terr, req_valid, rsp_ready} !== 4'b0000) begin miscompares++; $display("FAIL to_late_rsp: got %b want 0000", {tack, terr, req_valid, rsp_ready}); end
    rsp_valid = 1'b0;
    tick();
    vectors++; if (req_valid !== 1'b1 || req_dat[RW-1 -: AW] !== 32'h6000) begin miscompares++; $display("FAIL to_next_req: got v=%b adr=%h want 1/6000", req_valid, req_dat[RW-1 -: AW]); end
    tick();
    rsp_valid = 1'b1; rsp_dat = '0;
    tick();
    vectors++; if ({tack, terr} !== 2'b10) begin miscompares++; $display("FAIL to_next_ack: got %b want 10", {tack, terr}); end
    bus_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    bus_start(32'h3000, 32'h0000_00AA, 1'b1, 4'h1);
    tick(); tick();
    rsp_valid = 1'b1; rsp_dat = '0;
    tick();
    vectors++; if (tack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack0: got %b want 1", tack); end
    rsp_valid = 1'b0;
    bus_start(32'h3004, 32'h0000_00BB, 1'b1, 4'h2); // strobe held through ACK
    tick();
    vectors++; if ({tack, req_valid} !== 2'b00) begin miscompares++; $display("FAIL b2b_ack_ignore: got %b want 00", {tack, req_valid}); end
    tick();
    vectors++; if (req_valid !== 1'b1 || req_dat !== {32'h3004, 32'h0000_00BB, 1'b1, 4'h2}) begin miscompares++; $display("FAIL b2b_req1: got v=%b dat=%h", req_valid, req_dat); end
    tick();
    rsp_valid = 1'b1;
    tick();
    vectors++; if (tack !== 1'b1) begin miscompares++; $display("FAIL b2b_ack1: got %b want 1", tack); end
    bus_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    bus_start(32'h7000, 32'h7777_7777, 1'b1, 4'hF);
    tick(); tick(); // now in RSP
    #2 reset = 1'b1;
    #1;
    vectors++; if ({tack, terr, req_valid, rsp_ready} !== 4'b0 || tdat_r !== '0 || req_dat !== '0) begin miscompares++; $display("FAIL rst_mid: got ctl=%b dat_r=%h req=%h want 0", {tack, terr, req_valid, rsp_ready}, tdat_r, req_dat); end
    #1 reset = 1'b0;
    bus_idle();
    tick();
    bus_start(32'h8000, 32'h0, 1'b0, 4'hF);
    tick(); tick();
    rsp_valid = 1'b1; rsp_dat = {32'hBEEF_0001, 1'b0};
    tick();
    vectors++; if (tack !== 1'b1 || tdat_r !== 32'hBEEF_0001) begin miscompares++; $display("FAIL rst_after: got tack=%b dat=%h want 1/beef0001", tack, tdat_r); end
    bus_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_err_rsp();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
